ramp_gen: RTL
=============

# ramp_gen

Parametrised ramp/waveform generator for the LED fade and PWM path. It steps a wide accumulator by a programmable increment every enabled clock. Three modes are supported: triangle, sawtooth-up and sawtooth-down. The peak is programmable and all arithmetic saturates, so the accumulator never overshoots or wraps unintentionally. The top OUT_W bits drive the duty input of the downstream PWM; single-cycle Peak/Floor pulses let sequencers count periods.

## Interface
- ACC_W, 32, accumulator width; must satisfy ACC_W ≥ OUT_W and ACC_W ≥ STEP_W
- STEP_W, 8, width of the Step increment
- OUT_W, 8, width of Level and Ceiling
- Clock  in  1  system clock, all state on rising edge
- Reset  in  1  asynchronous, active-high; clears all state immediately
- Enable  in  1  1 = advance one step per clock; 0 = freeze all state
- Mode  in  2  00 triangle, 01 sawtooth-up, 10 sawtooth-down, 11 hold
- Step  in  STEP_W  unsigned increment added to or subtracted from Acc each cycle
- Ceiling  in  OUT_W  peak level; TOP = {Ceiling, (ACC_W−OUT_W) zeros}
- Level  out  OUT_W  Acc[ACC_W−1 : ACC_W−OUT_W]
- Dir  out  1  1 = counting up, 0 = counting down
- PeakPulse  out  1  one-cycle pulse on reaching TOP (triangle) or wrapping (saw-up)
- FloorPulse  out  1  one-cycle pulse on reaching 0 (triangle) or wrapping (saw-down)

## Operation
- State: Acc (ACC_W), Dir (1), PeakPulse, FloorPulse registers. Level is a combinational slice of Acc.
- Reset values: Acc=0, Dir=1, PeakPulse=0, FloorPulse=0, hence Level=0.
- Sum = Acc + Step is computed at ACC_W+1 bits. Diff compare uses Acc ≤ Step. No modular wrap is ever used.
- Advance condition: Enable=1, Mode≠11 and Step≠0. Otherwise Acc and Dir hold, and both pulses are 0 next cycle.
- Triangle, Dir=1:
  - If Sum ≥ TOP: Acc←TOP, Dir←0, PeakPulse←1.
  - Else: Acc←Sum.
- Triangle, Dir=0:
  - If Acc ≤ Step: Acc←0, Dir←1, FloorPulse←1.
  - Else: Acc←Acc−Step.
- Sawtooth-up: Dir←1.
  - If Sum ≥ TOP: Acc←0, PeakPulse←1.
  - Else: Acc←Sum.
- Sawtooth-down: Dir←0.
  - If Acc ≤ Step: Acc←TOP, FloorPulse←1.
  - Else: Acc←Acc−Step.
- Pulses are 0 in every cycle where no turn or wrap occurs.
- Ceiling lowered below Acc while rising: the next advance clamps Acc down to TOP and turns or wraps as above. While falling, descent continues normally.
- Ceiling=0 (TOP=0): triangle alternates Peak/Floor pulses with Acc=0. Saw-up pulses Peak every advance. Saw-down pulses Floor every advance. Acc stays 0 in all three cases.
- Mode change takes effect on the next advance, with no reset of Acc. Entering triangle keeps the current Dir.

## Timing
- One advance per enabled clock. Acc, Level and Dir update on the same edge.
- Each pulse is asserted in the cycle where Acc holds the turned or wrapped value, and lasts exactly one cycle.
- Reset is asynchronous: outputs take reset values without waiting for a clock. The first advance occurs on the first rising edge after Reset deasserts with Enable=1.
- Reset asserted mid-ramp or mid-pulse aborts immediately. No partial step or pending pulse survives.
- Enable deasserted on the cycle a pulse is showing: the pulse drops the next cycle and Acc holds.

## Test plan
Bench parameters: ACC_W=8, STEP_W=8, OUT_W=4, Ceiling=F (TOP=F0).
- Triangle, Step=30, Enable=1 after reset -> Acc 30,60,90,C0,F0,C0,90,60,30,00,30…. PeakPulse on the F0 cycle only; FloorPulse on the 00 cycle only; period 10 cycles; Level F at the peak.
- Saw-up, Step=50 -> Acc 50,A0,00,50,A0,00…. PeakPulse on each 00 cycle; Dir=1 throughout.
- Saw-down, Step=50 from reset -> Acc F0,A0,50,F0…. FloorPulse on each F0 cycle; Dir=0.
- Triangle Step=30 at Acc=C0 rising, Ceiling changed to 8 -> next Acc=80 with PeakPulse; then 50,20,00 with FloorPulse.
- Enable=0 or Mode=11 or Step=0 for 5 cycles at Acc=90 -> Acc, Dir and Level unchanged; no pulses; resumes from 90 afterwards.
- Reset pulsed asynchronously between edges at Acc=C0 -> Acc=0, Dir=1, pulses 0 before the next edge; restart matches scenario 1.

Source files
------------

// File: rtl/ramp_gen.sv
// Saturating ramp generator: triangle, sawtooth-up and sawtooth-down on a wide
// accumulator, with single-cycle pulses at the peak and floor turn/wrap points.
module ramp_gen #(
  parameter int unsigned ACC_W  = 32,
  parameter int unsigned STEP_W = 8,
  parameter int unsigned OUT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [STEP_W-1:0] step,
  input  logic [OUT_W-1:0]  ceiling,
  output logic [OUT_W-1:0]  level,
  output logic              dir,
  output logic              peak_pulse,
  output logic              floor_pulse
);

  localparam int unsigned PAD_W = ACC_W - OUT_W;
  localparam int unsigned SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {
    MODE_TRI  = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic             dir_q, dir_d;
  logic             peak_q, peak_d;
  logic             floor_q, floor_d;

  logic [ACC_W-1:0] top_c;
  logic [ACC_W-1:0] step_ext_c;
  logic [SUM_W-1:0] sum_c;
  logic             advance_c;
  logic             at_top_c;
  logic             at_floor_c;

  // Sum is one bit wider than Acc so the peak compare never sees a wrap.
  assign top_c      = ACC_W'(ceiling) << PAD_W;
  assign step_ext_c = ACC_W'(step);
  assign sum_c      = SUM_W'(acc_q) + SUM_W'(step_ext_c);
  assign at_top_c   = (sum_c >= SUM_W'(top_c));
  assign at_floor_c = (acc_q <= step_ext_c);
  assign advance_c  = enable && (mode != MODE_HOLD) && (step != '0);

  // Next-state logic; pulses default low so they last exactly one cycle.
  always_comb begin
    acc_d   = acc_q;
    dir_d   = dir_q;
    peak_d  = 1'b0;
    floor_d = 1'b0;
    if (advance_c) begin
      case (mode_e'(mode))
        MODE_TRI: begin
          if (dir_q) begin
            if (at_top_c) begin
              acc_d  = top_c;
              dir_d  = 1'b0;
              peak_d = 1'b1;
            end else begin
              acc_d = sum_c[ACC_W-1:0];
            end
          end else begin
            if (at_floor_c) begin
              acc_d   = '0;
              dir_d   = 1'b1;
              floor_d = 1'b1;
            end else begin
              acc_d = acc_q - step_ext_c;
            end
          end
        end
        MODE_UP: begin
          dir_d = 1'b1;
          if (at_top_c) begin
            acc_d  = '0;
            peak_d = 1'b1;
          end else begin
            acc_d = sum_c[ACC_W-1:0];
          end
        end
        MODE_DOWN: begin
          dir_d = 1'b0;
          if (at_floor_c) begin
            acc_d   = top_c;
            floor_d = 1'b1;
          end else begin
            acc_d = acc_q - step_ext_c;
          end
        end
        default: begin
          acc_d = acc_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      dir_q   <= 1'b1;
      peak_q  <= 1'b0;
      floor_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      dir_q   <= dir_d;
      peak_q  <= peak_d;
      floor_q <= floor_d;
    end
  end

  assign level       = acc_q[ACC_W-1 -: OUT_W];
  assign dir         = dir_q;
  assign peak_pulse  = peak_q;
  assign floor_pulse = floor_q;

endmodule
